// File: rtl/dco_bank_ctrl_if.sv
// Request/response bundle between the ADPLL normalisation logic and one DCO bank controller.
// The master drives a code request; the slave returns the applied code and the cell-select matrix.
interface dco_bank_ctrl_if #(
  parameter int unsigned ROWS = 16,
  parameter int unsigned COLS = 16,
  parameter int unsigned W    = $clog2(ROWS*COLS+1)
);
  logic [W-1:0]    code_i;
  logic            code_valid;
  logic            code_ready;
  logic            jump;
  logic [ROWS-1:0] rall;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic [W-1:0]    code_o;
  logic            busy;

  modport master (
    output code_i, code_valid, jump,
    input  code_ready, rall, row, col, code_o, busy
  );

  modport slave (
    input  code_i, code_valid, jump,
    output code_ready, rall, row, col, code_o, busy
  );
endinterface

// File: rtl/dco_bank_ctrl.sv
// DCO capacitor-bank controller: maps a bank code onto the row-all/row/column select matrix,
// applying requests immediately (jump) or rate-limited (slew), followed by a settle window.
module dco_bank_ctrl #(
  parameter int unsigned ROWS       = 16,
  parameter int unsigned COLS       = 16,
  parameter int unsigned W          = $clog2(ROWS*COLS+1),
  parameter int unsigned MAX_STEP   = 4,
  parameter int unsigned STEP_DIV   = 2,
  parameter int unsigned SETTLE_CYC = 3
) (
  input logic            clk,
  input logic            rst,
  dco_bank_ctrl_if.slave bus
);

  localparam int unsigned CELLS      = ROWS * COLS;
  localparam int unsigned STEP_CLAMP = (MAX_STEP > CELLS) ? CELLS : MAX_STEP;
  localparam int unsigned DIV_W      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned SET_W      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned DIV_LAST   = (STEP_DIV > 0) ? STEP_DIV - 1 : 0;
  localparam int unsigned SET_LAST   = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SLEW   = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  // A zero-length settle window returns straight to IDLE once the code lands.
  localparam logic [1:0] POST   = (SETTLE_CYC == 0) ? IDLE : SETTLE;

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     code_q, code_d;
  logic [W-1:0]     target_q, target_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [SET_W-1:0] settle_q, settle_d;

  logic [W-1:0]     sat_code;
  logic [W-1:0]     diff;
  logic [W-1:0]     step;
  logic [W-1:0]     next_code;
  logic             going_up;

  logic [ROWS-1:0]  rall_d;
  logic [ROWS-1:0]  row_d;
  logic [COLS-1:0]  col_d;

  // Saturated request and one rate-limited step from the current code toward the target.
  always_comb begin
    sat_code  = (bus.code_i > W'(CELLS)) ? W'(CELLS) : bus.code_i;
    going_up  = target_q > code_q;
    diff      = going_up ? (target_q - code_q) : (code_q - target_q);
    step      = (diff > W'(STEP_CLAMP)) ? W'(STEP_CLAMP) : diff;
    next_code = going_up ? (code_q + step) : (code_q - step);
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    target_d = target_q;
    div_d    = div_q;
    settle_d = settle_q;
    case (state_q)
      IDLE: begin
        if (bus.code_valid && bus.code_ready) begin
          target_d = sat_code;
          if (bus.jump || (sat_code == code_q)) begin
            code_d   = sat_code;
            state_d  = POST;
            settle_d = '0;
          end else begin
            state_d = SLEW;
            div_d   = '0;
          end
        end
      end
      SLEW: begin
        if (div_q == DIV_W'(DIV_LAST)) begin
          div_d  = '0;
          code_d = next_code;
          if (next_code == target_q) begin
            state_d  = POST;
            settle_d = '0;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SETTLE: begin
        if (settle_q == SET_W'(SET_LAST)) begin
          state_d = IDLE;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Thermometer decode of the next code so the matrix lands on the same edge as code_o.
  always_comb begin
    rall_d = '0;
    row_d  = '0;
    col_d  = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      rall_d[r] = code_d >= W'((r + 1) * COLS);
      row_d[r]  = (code_d >= W'(r * COLS)) && (code_d < W'((r + 1) * COLS));
      for (int c = 0; c < int'(COLS); c++) begin
        if (row_d[r] && (code_d >= W'(r * COLS + c + 1))) col_d[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      code_q         <= '0;
      target_q       <= '0;
      div_q          <= '0;
      settle_q       <= '0;
      bus.code_o     <= '0;
      bus.rall       <= '0;
      bus.row        <= ROWS'(1);
      bus.col        <= '0;
      bus.busy       <= 1'b0;
      bus.code_ready <= 1'b1;
    end else begin
      state_q        <= state_d;
      code_q         <= code_d;
      target_q       <= target_d;
      div_q          <= div_d;
      settle_q       <= settle_d;
      bus.code_o     <= code_d;
      bus.rall       <= rall_d;
      bus.row        <= row_d;
      bus.col        <= col_d;
      bus.busy       <= (state_d != IDLE);
      bus.code_ready <= (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_dco_bank_ctrl.sv
// Directed bench for dco_bank_ctrl: a 16x16 bank (slew/jump/saturation/reset) and a 5x5 bank.
module tb_dco_bank_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dco_bank_ctrl_if #(.ROWS(16), .COLS(16)) ba ();
  dco_bank_ctrl_if #(.ROWS(5),  .COLS(5))  bb ();

  dco_bank_ctrl #(.ROWS(16), .COLS(16)) dut_a (.clk(clk), .rst(rst), .bus(ba.slave));
  dco_bank_ctrl #(.ROWS(5),  .COLS(5))  dut_b (.clk(clk), .rst(rst), .bus(bb.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Selected-cell count of the 16x16 matrix: cell(r,c) = rall[r] | (row[r] & col[c]).
  function automatic int cells_a();
    int n = 0;
    for (int r = 0; r < 16; r++) begin
      if (ba.rall[r]) n += 16;
      else if (ba.row[r]) n += $countones(ba.col);
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle request on bank A; returns just after the accept edge.
  task automatic send_a(input int code, input logic j);
    ba.code_i     = 9'(code);
    ba.jump       = j;
    ba.code_valid = 1'b1;
    tick();
    ba.code_valid = 1'b0;
  endtask

  task automatic wait_idle_a(input int n);
    for (int i = 0; i < n; i++) tick();
    check("idle_ready", 32'(ba.code_ready), 32'd1);
  endtask

  initial begin
    int exp_up[6]   = '{0, 4, 4, 8, 8, 10};
    int exp_down[6] = '{10, 6, 6, 2, 2, 1};
    ba.code_i = '0; ba.code_valid = 1'b0; ba.jump = 1'b0;
    bb.code_i = '0; bb.code_valid = 1'b0; bb.jump = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_code", 32'(ba.code_o), 32'd0);
    check("rst_rall", 32'(ba.rall), 32'h0);
    check("rst_row", 32'(ba.row), 32'h1);
    check("rst_col", 32'(ba.col), 32'h0);
    check("rst_busy", 32'(ba.busy), 32'd0);
    check("rst_ready", 32'(ba.code_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Jump to 37: q=2, rem=5
    send_a(37, 1'b1);
    check("j37_code", 32'(ba.code_o), 32'd37);
    check("j37_rall", 32'(ba.rall), 32'h0003);
    check("j37_row", 32'(ba.row), 32'h0004);
    check("j37_col", 32'(ba.col), 32'h001F);
    check("j37_busy0", 32'(ba.busy), 32'd1);
    for (int i = 1; i <= 2; i++) begin
      tick();
      check("j37_busy", 32'(ba.busy), 32'd1);
    end
    tick();
    check("j37_done", 32'(ba.busy), 32'd0);
    check("j37_ready", 32'(ba.code_ready), 32'd1);

    // Back to 0 so the slew tests start from a known code
    send_a(0, 1'b1);
    check("j0_code", 32'(ba.code_o), 32'd0);
    wait_idle_a(3);

    // Slew up 0 -> 10
    send_a(10, 1'b0);
    check("up_busy", 32'(ba.busy), 32'd1);
    check("up_ready", 32'(ba.code_ready), 32'd0);
    for (int t = 1; t <= 6; t++) begin
      tick();
      check("up_code", 32'(ba.code_o), 32'(exp_up[t-1]));
      check("up_pop", 32'(cells_a()), 32'(ba.code_o));
    end
    tick(); check("up_settle1", 32'(ba.busy), 32'd1);
    tick(); check("up_settle2", 32'(ba.busy), 32'd1);
    tick(); check("up_busy_end", 32'(ba.busy), 32'd0);

    // Slew down 10 -> 1
    send_a(1, 1'b0);
    for (int t = 1; t <= 6; t++) begin
      tick();
      check("dn_code", 32'(ba.code_o), 32'(exp_down[t-1]));
      check("dn_pop", 32'(cells_a()), 32'(ba.code_o));
    end
    check("dn_rall", 32'(ba.rall), 32'h0);
    check("dn_row", 32'(ba.row), 32'h1);
    check("dn_col", 32'(ba.col), 32'h1);
    wait_idle_a(3);

    // Slew 1 -> 20 with an ignored jump request to 50 mid-slew
    send_a(20, 1'b0);
    tick(); tick();
    check("ign_code_t2", 32'(ba.code_o), 32'd5);
    ba.code_i = 9'd50; ba.jump = 1'b1; ba.code_valid = 1'b1;
    tick();
    ba.code_valid = 1'b0;
    check("ign_code_t3", 32'(ba.code_o), 32'd5);
    tick();
    check("ign_code_t4", 32'(ba.code_o), 32'd9);
    for (int t = 5; t <= 10; t++) tick();
    check("ign_final", 32'(ba.code_o), 32'd20);
    wait_idle_a(3);
    check("ign_hold", 32'(ba.code_o), 32'd20);

    // Request equal to current code: immediate settle, matrix unchanged
    send_a(20, 1'b0);
    check("eq_code", 32'(ba.code_o), 32'd20);
    check("eq_rall", 32'(ba.rall), 32'h0001);
    check("eq_row", 32'(ba.row), 32'h0002);
    check("eq_col", 32'(ba.col), 32'h000F);
    check("eq_busy", 32'(ba.busy), 32'd1);
    wait_idle_a(3);

    // Saturation: 300 -> 256
    send_a(300, 1'b1);
    check("sat_code", 32'(ba.code_o), 32'd256);
    check("sat_rall", 32'(ba.rall), 32'hFFFF);
    check("sat_row", 32'(ba.row), 32'h0000);
    check("sat_col", 32'(ba.col), 32'h0000);
    wait_idle_a(3);

    // Reset in the middle of a slew
    send_a(0, 1'b1);
    wait_idle_a(3);
    send_a(12, 1'b0);
    for (int t = 1; t <= 4; t++) tick();
    check("mid_code", 32'(ba.code_o), 32'd8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_code", 32'(ba.code_o), 32'd0);
    check("mr_row", 32'(ba.row), 32'h1);
    check("mr_rall", 32'(ba.rall), 32'h0);
    check("mr_col", 32'(ba.col), 32'h0);
    check("mr_busy", 32'(ba.busy), 32'd0);
    check("mr_ready", 32'(ba.code_ready), 32'd1);
    tick(); tick();
    check("mr_stay", 32'(ba.code_o), 32'd0);

    // 5x5 bank: jump to 25 (full) and to 7 (q=1, rem=2)
    bb.code_i = 5'd25; bb.jump = 1'b1; bb.code_valid = 1'b1;
    tick();
    bb.code_valid = 1'b0;
    check("b25_code", 32'(bb.code_o), 32'd25);
    check("b25_rall", 32'(bb.rall), 32'h1F);
    check("b25_row", 32'(bb.row), 32'h00);
    check("b25_col", 32'(bb.col), 32'h00);
    for (int i = 0; i < 3; i++) tick();
    check("b_ready", 32'(bb.code_ready), 32'd1);
    bb.code_i = 5'd7; bb.jump = 1'b1; bb.code_valid = 1'b1;
    tick();
    bb.code_valid = 1'b0;
    check("b7_rall", 32'(bb.rall), 32'h01);
    check("b7_row", 32'(bb.row), 32'h02);
    check("b7_col", 32'(bb.col), 32'h03);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
